// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Wait-stated data-memory responder for the pipeline's MEM stage. Accepts one
//   load or store at a time, holds the pipeline with Mem_Stall, and answers with
//   a one-cycle Ready pulse after WAIT_CYCLES extra cycles. Byte lanes are
//   big-endian (offset 0 is bits [31:24]). Loads are sign- or zero-extended.
//   Conflicting, misaligned or out-of-range requests are rejected with
//   Addr_Error and leave the memory untouched.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-low reset
//   MemRead       load size  (00 none, 01 byte, 10 halfword, 11 word)
//   MemWrite      store size (same encoding)
//   Load_unsigned 1 = zero-extend byte/halfword loads, 0 = sign-extend
//   Address       byte address
//   Write_data    right-justified store data
//   Read_data     load result, held until the next response
//   Ready         one-cycle response pulse
//   Addr_Error    request rejected (qualifies Ready)
//   Mem_Stall     request present and no Ready this cycle
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  MemRead,
    input  logic [1:0]  MemWrite,
    input  logic        Load_unsigned,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        Ready,
    output logic        Addr_Error,
    output logic        Mem_Stall
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [1:0]  rd_q, wr_q;
    logic        uns_q;
    logic [31:0] addr_q, wdata_q;
    logic        ready_q, err_q;
    logic [31:0] rdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    // Operation currently being evaluated. In IDLE the live inputs are used so
    // that WAIT_CYCLES=0 can respond straight from IDLE; afterwards the latched
    // copy is used, so input changes in WAIT/RESP cannot disturb the operation.
    logic [1:0]  op_rd, op_wr, op_size;
    logic        op_uns;
    logic [31:0] op_addr, op_wdata;

    logic          req_present, enter_resp, op_err, do_write;
    logic [AW-1:0] idx;
    logic [31:0]   word_rd, size_mask, lane_mask, wr_merged, load_val;
    logic [4:0]    shift;
    logic [15:0]   lane;

    assign req_present = (MemRead != 2'b00) || (MemWrite != 2'b00);

    always_comb begin
        if (state_q == S_IDLE) begin
            op_rd    = MemRead;
            op_wr    = MemWrite;
            op_uns   = Load_unsigned;
            op_addr  = Address;
            op_wdata = Write_data;
        end else begin
            op_rd    = rd_q;
            op_wr    = wr_q;
            op_uns   = uns_q;
            op_addr  = addr_q;
            op_wdata = wdata_q;
        end
    end

    assign op_size = (op_rd != 2'b00) ? op_rd : op_wr;
    assign op_err  = ((op_rd != 2'b00) && (op_wr != 2'b00))
                   || ((op_size == 2'b10) && op_addr[0])
                   || ((op_size == 2'b11) && (op_addr[1:0] != 2'b00))
                   || ({2'b00, op_addr[31:2]} >= 32'(DEPTH_WORDS));

    assign idx     = op_addr[AW+1:2];
    assign word_rd = mem[idx];

    // Big-endian lane position: byte offset o sits (3-o) bytes above bit 0,
    // halfword offset 0/2 sits 2/0 bytes above bit 0.
    always_comb begin
        shift     = 5'd0;
        size_mask = 32'hFFFF_FFFF;
        case (op_size)
            2'b01: begin
                shift     = {~op_addr[1:0], 3'b000};
                size_mask = 32'h0000_00FF;
            end
            2'b10: begin
                shift     = {~op_addr[1], 4'b0000};
                size_mask = 32'h0000_FFFF;
            end
            default: ;
        endcase
    end

    assign lane_mask = size_mask << shift;
    assign wr_merged = (word_rd & ~lane_mask) | ((op_wdata & size_mask) << shift);
    assign lane      = 16'(word_rd >> shift);

    always_comb begin
        case (op_size)
            2'b01:   load_val = {{24{~op_uns & lane[7]}},  lane[7:0]};
            2'b10:   load_val = {{16{~op_uns & lane[15]}}, lane[15:0]};
            default: load_val = word_rd;
        endcase
    end

    assign enter_resp = rst && (((state_q == S_IDLE) && req_present && (WAIT_CYCLES == 0))
                             || ((state_q == S_WAIT) && (cnt_q == 4'd0)));
    assign do_write   = enter_resp && !op_err && (op_wr != 2'b00);

    // NOTE: storage is deliberately left out of reset; clearing a RAM array is
    // not synthesizable as a block RAM, and only the control state needs it.
    always_ff @(posedge clk) begin
        if (do_write) mem[idx] <= wr_merged;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= 2'b00;
            wr_q    <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_present) begin
                        rd_q    <= MemRead;
                        wr_q    <= MemWrite;
                        uns_q   <= Load_unsigned;
                        addr_q  <= Address;
                        wdata_q <= Write_data;
                        if (WAIT_CYCLES > 0) begin
                            state_q <= S_WAIT;
                            cnt_q   <= 4'(WAIT_CYCLES - 1);
                        end else begin
                            state_q <= S_RESP;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) state_q <= S_RESP;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase

            // Response registers load on the edge entering RESP.
            if (enter_resp) begin
                ready_q <= 1'b1;
                err_q   <= op_err;
                rdata_q <= (op_err || (op_rd == 2'b00)) ? 32'd0 : load_val;
            end
        end
    end

    assign Ready      = ready_q;
    assign Addr_Error = err_q;
    assign Read_data  = rdata_q;
    assign Mem_Stall  = req_present && !ready_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  mem_read = 2'b00, mem_write = 2'b00;
    logic        load_uns = 1'b0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic        sel0 = 1'b0;  // 0: drive the WAIT_CYCLES=2 unit, 1: the WAIT_CYCLES=0 unit

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    int ready_cycle = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    logic [1:0]  mr2, mw2, mr0, mw0;
    logic [31:0] rd2, rd0;
    logic        rdy2, rdy0, err2, err0, stl2, stl0;

    assign mr2 = sel0 ? 2'b00 : mem_read;
    assign mw2 = sel0 ? 2'b00 : mem_write;
    assign mr0 = sel0 ? mem_read  : 2'b00;
    assign mw0 = sel0 ? mem_write : 2'b00;

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .MemRead(mr2), .MemWrite(mw2), .Load_unsigned(load_uns),
        .Address(addr), .Write_data(wdata), .Read_data(rd2), .Ready(rdy2),
        .Addr_Error(err2), .Mem_Stall(stl2));

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst(rst), .MemRead(mr0), .MemWrite(mw0), .Load_unsigned(load_uns),
        .Address(addr), .Write_data(wdata), .Read_data(rd0), .Ready(rdy0),
        .Addr_Error(err0), .Mem_Stall(stl0));

    logic [31:0] o_rdata;
    logic        o_ready, o_err, o_stall;
    assign o_rdata = sel0 ? rd0  : rd2;
    assign o_ready = sel0 ? rdy0 : rdy2;
    assign o_err   = sel0 ? err0 : err2;
    assign o_stall = sel0 ? stl0 : stl2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request (called just after a rising edge) and wait for Ready.
    task automatic access(input logic [1:0] rd, input logic [1:0] wr, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output int stalls);
        mem_read = rd; mem_write = wr; load_uns = uns; addr = a; wdata = wd;
        lat = -1; stalls = 0; rdata = 32'd0; err = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (o_stall) stalls++;
            if (o_ready) begin
                lat = c; rdata = o_rdata; err = o_err; ready_cycle = cycle;
                break;
            end
        end
        @(posedge clk); #1;
        mem_read = 2'b00; mem_write = 2'b00; load_uns = 1'b0; addr = 32'd0; wdata = 32'd0;
    endtask

    function automatic int exp_lat();
        return sel0 ? 1 : 3;
    endfunction

    task automatic do_store(input string tag, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd);
        logic [31:0] r; logic e; int lat, st;
        access(2'b00, sz, 1'b0, a, wd, r, e, lat, st);
        check({tag, " lat"}, 32'(lat), 32'(exp_lat()));
        check({tag, " err"}, {31'd0, e}, 32'd0);
    endtask

    task automatic load_check(input string tag, input logic [1:0] sz, input logic uns,
                              input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r; logic e; int lat, st;
        access(sz, 2'b00, uns, a, 32'd0, r, e, lat, st);
        check({tag, " lat"}, 32'(lat), 32'(exp_lat()));
        check({tag, " data"}, r, exp);
    endtask

    task automatic err_check(input string tag, input logic [1:0] rd, input logic [1:0] wr,
                             input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] r; logic e; int lat, st;
        access(rd, wr, 1'b0, a, wd, r, e, lat, st);
        check({tag, " lat"}, 32'(lat), 32'(exp_lat()));
        check({tag, " err"}, {31'd0, e}, 32'd1);
        check({tag, " data"}, r, 32'd0);
    endtask

    initial begin
        logic [31:0] r; logic e; int lat, st, any_ready, t1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst ready", {31'd0, rdy2}, 32'd0);
        check("rst err",   {31'd0, err2}, 32'd0);
        check("rst rdata", rd2, 32'd0);
        check("rst stall", {31'd0, stl2}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Word store then load: Ready in cycle 3, stall in cycles 0..2
        access(2'b00, 2'b11, 1'b0, 32'h10, 32'hDEADBEEF, r, e, lat, st);
        check("st word lat", 32'(lat), 32'd3);
        check("st word stalls", 32'(st), 32'd3);
        check("st word err", {31'd0, e}, 32'd0);
        load_check("ld word 0x10", 2'b11, 1'b0, 32'h10, 32'hDEADBEEF);

        // Byte lanes
        do_store("st 0x20", 2'b11, 32'h20, 32'h11223344);
        do_store("st byte 0x22", 2'b01, 32'h22, 32'hFFFFFFA5);
        load_check("ld word after byte", 2'b11, 1'b0, 32'h20, 32'h1122A544);
        load_check("ld byte 0x22 s", 2'b01, 1'b0, 32'h22, 32'hFFFFFFA5);
        load_check("ld byte 0x22 u", 2'b01, 1'b1, 32'h22, 32'h000000A5);
        load_check("ld byte 0x20 s", 2'b01, 1'b0, 32'h20, 32'h00000011);
        load_check("ld byte 0x23 u", 2'b01, 1'b1, 32'h23, 32'h00000044);

        // Halfword lanes
        do_store("st half 0x20", 2'b10, 32'h20, 32'h12348000);
        load_check("ld half 0x20 s", 2'b10, 1'b0, 32'h20, 32'hFFFF8000);
        load_check("ld half 0x20 u", 2'b10, 1'b1, 32'h20, 32'h00008000);
        load_check("ld half 0x22 s", 2'b10, 1'b0, 32'h22, 32'hFFFFA544);
        do_store("st half 0x22", 2'b10, 32'h22, 32'h00001234);
        load_check("ld word half mix", 2'b11, 1'b1, 32'h20, 32'h80001234);

        // Errors
        err_check("err word 0x21", 2'b11, 2'b00, 32'h21, 32'd0);
        err_check("err half st 0x23", 2'b00, 2'b10, 32'h23, 32'h0000FFFF);
        load_check("reread 0x20 a", 2'b11, 1'b0, 32'h20, 32'h80001234);
        do_store("st 0x0", 2'b11, 32'h0, 32'hCAFEF00D);
        err_check("err range st", 2'b00, 2'b11, 32'h400, 32'h55555555);
        load_check("reread 0x0", 2'b11, 1'b0, 32'h0, 32'hCAFEF00D);
        err_check("err rd+wr", 2'b11, 2'b11, 32'h20, 32'h0);
        load_check("reread 0x20 b", 2'b11, 1'b0, 32'h20, 32'h80001234);

        // Reset during a store
        do_store("st 0x30", 2'b11, 32'h30, 32'h01020304);
        load_check("ld 0x30 pre", 2'b11, 1'b0, 32'h30, 32'h01020304);
        mem_read = 2'b00; mem_write = 2'b11; addr = 32'h30; wdata = 32'h99999999;
        @(posedge clk); #1;            // now in cycle 1 (WAIT)
        rst = 1'b0;
        mem_write = 2'b00; addr = 32'd0; wdata = 32'd0;
        @(posedge clk); #1;
        any_ready = 0;
        @(negedge clk);
        check("midrst ready", {31'd0, rdy2}, 32'd0);
        check("midrst err",   {31'd0, err2}, 32'd0);
        check("midrst rdata", rd2, 32'd0);
        check("midrst stall", {31'd0, stl2}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rdy2) any_ready++;
        end
        check("midrst no ready", 32'(any_ready), 32'd0);
        @(posedge clk); #1;
        load_check("ld 0x30 post", 2'b11, 1'b0, 32'h30, 32'h01020304);

        // Back-to-back on the WAIT_CYCLES=0 unit
        sel0 = 1'b1;
        do_store("w0 st 0x4", 2'b11, 32'h4, 32'hA1A1A1A1);
        do_store("w0 st 0x8", 2'b11, 32'h8, 32'hB2B2B2B2);
        t1 = cycle;                     // cycle 0 of the first load
        load_check("w0 ld 0x4", 2'b11, 1'b0, 32'h4, 32'hA1A1A1A1);
        check("w0 ready1 cycle", 32'(ready_cycle - t1), 32'd1);
        load_check("w0 ld 0x8", 2'b11, 1'b0, 32'h8, 32'hB2B2B2B2);
        check("w0 ready2 cycle", 32'(ready_cycle - t1), 32'd3);
        sel0 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
